// File: rtl/commit_stage_pkg.sv
// Shared types and constants for the commit/writeback stage and its register file.
package commit_stage_pkg;

  localparam int REG_COUNT = 32;

  typedef logic [31:0] REG_WIDTH;
  typedef logic [4:0]  REG_ADDR;
  typedef logic        bool;

  // One retiring instruction as handed over by the memory stage.
  typedef struct packed {
    REG_WIDTH result;
    bool      write_reg_need;
    REG_ADDR  write_reg_addr;
  } CMT_REQUIRE;

  // An empty slot: no write, address 0, zero result.
  localparam CMT_REQUIRE CMT_BUBBLE = '{result: '0, write_reg_need: 1'b0, write_reg_addr: '0};

  // A slot only retires a register write if it asks for one and does not target r0.
  function automatic bool effective_write(input CMT_REQUIRE slot);
    return slot.write_reg_need && (slot.write_reg_addr != '0);
  endfunction

endpackage

// File: rtl/commit_stage_regfile_2w4r.sv
// Architectural register file: two ordered write ports, NUM_READ raw read ports.
// Register 0 is held at zero; slot 1's write overrides slot 0's on an address clash.
module regfile_2w4r
  import commit_stage_pkg::*;
#(
  parameter int NUM_READ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic     [1:0]           wen,
  input  REG_ADDR  [1:0]           waddr,
  input  REG_WIDTH [1:0]           wdata,
  input  REG_ADDR  [NUM_READ-1:0]  raddr,
  output REG_WIDTH [NUM_READ-1:0]  rdata
);

  REG_WIDTH regs_q [REG_COUNT];

  // Clear everything on reset; otherwise apply slot 0 then slot 1 so the younger write lands last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wen[0] && (waddr[0] != '0)) begin
        regs_q[waddr[0]] <= wdata[0];
      end
      if (wen[1] && (waddr[1] != '0)) begin
        regs_q[waddr[1]] <= wdata[1];
      end
    end
  end

  // Raw array lookups; bypassing is the caller's job.
  always_comb begin
    for (int p = 0; p < NUM_READ; p++) begin
      rdata[p] = regs_q[raddr[p]];
    end
  end

endmodule

// File: rtl/commit_stage.sv
// Dual-issue commit stage: registers the two retiring slots (bubbling on stall/flush),
// writes them into the register file, bypasses them to the decode read ports and
// counts retired register writes.
module commit_stage
  import commit_stage_pkg::*;
#(
  parameter int NUM_READ = 4,
  parameter int CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  CMT_REQUIRE [1:0]         cmt_require,
  input  logic                     stall_from_memory,
  input  logic                     flush,
  input  REG_ADDR  [NUM_READ-1:0]  read_addr,
  output REG_WIDTH [NUM_READ-1:0]  read_data,
  output logic     [CNT_W-1:0]     commit_count
);

  CMT_REQUIRE [1:0]   cmt_q, cmt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         wen;
  REG_ADDR  [1:0]     waddr;
  REG_WIDTH [1:0]     wdata;
  REG_WIDTH [NUM_READ-1:0] array_data;

  // Next stage contents: a bubble whenever the memory stage has nothing valid or we are flushing.
  always_comb begin
    cmt_d = cmt_require;
    if (flush || stall_from_memory) begin
      cmt_d[0] = CMT_BUBBLE;
      cmt_d[1] = CMT_BUBBLE;
    end
  end

  // Per-slot effective write enables and the data presented to the array.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      wen[s]   = effective_write(cmt_q[s]);
      waddr[s] = cmt_q[s].write_reg_addr;
      wdata[s] = cmt_q[s].result;
    end
  end

  // Retired-write counter advances by 0, 1 or 2 and wraps silently.
  always_comb begin
    count_d = count_q + {{(CNT_W-1){1'b0}}, wen[0]} + {{(CNT_W-1){1'b0}}, wen[1]};
  end

  // Stage register and counter; reset dominates stall and flush and drops pending writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmt_q[0] <= CMT_BUBBLE;
      cmt_q[1] <= CMT_BUBBLE;
      count_q  <= '0;
    end else begin
      cmt_q    <= cmt_d;
      count_q  <= count_d;
    end
  end

  regfile_2w4r #(
    .NUM_READ (NUM_READ)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (read_addr),
    .rdata (array_data)
  );

  // Read ports: r0 is zero, then the younger slot, then the older slot, then the array.
  always_comb begin
    for (int p = 0; p < NUM_READ; p++) begin
      if (read_addr[p] == '0) begin
        read_data[p] = '0;
      end else if (wen[1] && (read_addr[p] == cmt_q[1].write_reg_addr)) begin
        read_data[p] = cmt_q[1].result;
      end else if (wen[0] && (read_addr[p] == cmt_q[0].write_reg_addr)) begin
        read_data[p] = cmt_q[0].result;
      end else begin
        read_data[p] = array_data[p];
      end
    end
  end

  assign commit_count = count_q;

endmodule

// File: tb/tb_commit_stage.sv
// Directed testbench for commit_stage with a 4-bit commit counter.
module tb_commit_stage;
  import commit_stage_pkg::*;

  localparam int NUM_READ = 4;
  localparam int CNT_W    = 4;

  logic                     clk;
  logic                     rst_n;
  CMT_REQUIRE [1:0]         cmt_require;
  logic                     stall_from_memory;
  logic                     flush;
  REG_ADDR  [NUM_READ-1:0]  read_addr;
  REG_WIDTH [NUM_READ-1:0]  read_data;
  logic     [CNT_W-1:0]     commit_count;

  int passCount  = 0;
  int checkCount = 0;

  commit_stage #(
    .NUM_READ (NUM_READ),
    .CNT_W    (CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmt_require       (cmt_require),
    .stall_from_memory (stall_from_memory),
    .flush             (flush),
    .read_addr         (read_addr),
    .read_data         (read_data),
    .commit_count      (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive both slots plus stall/flush, then let one rising edge capture them.
  task automatic applyStimulus(input logic n0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic n1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic st, input logic fl);
    cmt_require[0].write_reg_need = n0;
    cmt_require[0].write_reg_addr = a0;
    cmt_require[0].result         = d0;
    cmt_require[1].write_reg_need = n1;
    cmt_require[1].write_reg_addr = a1;
    cmt_require[1].result         = d1;
    stall_from_memory             = st;
    flush                         = fl;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  function automatic logic [31:0] cnt();
    return {{(32-CNT_W){1'b0}}, commit_count};
  endfunction

  initial begin
    rst_n        = 1'b0;
    read_addr[0] = 5'd5;
    read_addr[1] = 5'd7;
    read_addr[2] = 5'd3;
    read_addr[3] = 5'd4;

    // Reset held for two edges while valid writes are presented.
    applyStimulus(1, 5, 32'hAAAA_AAAA, 1, 7, 32'hBBBB_BBBB, 0, 0);
    applyStimulus(1, 5, 32'hAAAA_AAAA, 1, 7, 32'hBBBB_BBBB, 0, 0);
    checkOutput("reset_count", cnt(), 32'd0);
    rst_n = 1'b1;
    cmt_require[0] = CMT_BUBBLE;
    cmt_require[1] = CMT_BUBBLE;
    #1;
    checkOutput("reset_rd_r5", read_data[0], 32'd0);
    checkOutput("reset_rd_r7", read_data[1], 32'd0);
    checkOutput("reset_rd_r3", read_data[2], 32'd0);

    // Basic write: bypass in the cycle after capture, array one cycle later.
    applyStimulus(1, 5, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 0);
    checkOutput("bypass_r5", read_data[0], 32'hDEAD_BEEF);
    checkOutput("count_before_retire", cnt(), 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    checkOutput("array_r5", read_data[0], 32'hDEAD_BEEF);
    checkOutput("count_one", cnt(), 32'd1);

    // Same-address dual write: the younger slot wins in bypass and in the array.
    applyStimulus(1, 7, 32'h11, 1, 7, 32'h22, 0, 0);
    checkOutput("dual_bypass_r7", read_data[1], 32'h22);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    checkOutput("dual_array_r7", read_data[1], 32'h22);
    checkOutput("dual_count", cnt(), 32'd3);

    // Stall then flush: both captured as bubbles.
    applyStimulus(1, 3, 32'h55, 0, 0, 32'h0, 1, 0);
    checkOutput("stall_r3_now", read_data[2], 32'd0);
    applyStimulus(1, 4, 32'h66, 0, 0, 32'h0, 0, 1);
    checkOutput("flush_r4_now", read_data[3], 32'd0);
    applyStimulus(1, 4, 32'h77, 1, 3, 32'h88, 1, 1);
    checkOutput("stall_flush_r4", read_data[3], 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    checkOutput("stall_r3_later", read_data[2], 32'd0);
    checkOutput("flush_r4_later", read_data[3], 32'd0);
    checkOutput("stall_flush_count", cnt(), 32'd3);

    // r0 write and a slot with no write request.
    read_addr[0] = 5'd0;
    read_addr[1] = 5'd9;
    applyStimulus(1, 0, 32'hFFFF, 0, 9, 32'h1, 0, 0);
    checkOutput("r0_bypass", read_data[0], 32'd0);
    checkOutput("r9_bypass", read_data[1], 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    checkOutput("r0_array", read_data[0], 32'd0);
    checkOutput("r9_array", read_data[1], 32'd0);
    checkOutput("nowrite_count", cnt(), 32'd3);

    // Back-to-back writes to r5: bypass always shows the youngest value.
    read_addr[0] = 5'd5;
    applyStimulus(1, 5, 32'h1, 0, 0, 32'h0, 0, 0);
    checkOutput("b2b_first", read_data[0], 32'h1);
    applyStimulus(0, 0, 32'h0, 1, 5, 32'h2, 0, 0);
    checkOutput("b2b_second", read_data[0], 32'h2);
    checkOutput("b2b_count_mid", cnt(), 32'd4);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    checkOutput("b2b_array", read_data[0], 32'h2);
    checkOutput("b2b_count", cnt(), 32'd5);

    // Reset mid-stream drops the pending write to r6.
    read_addr[3] = 5'd6;
    applyStimulus(1, 6, 32'h77, 0, 0, 32'h0, 0, 0);
    checkOutput("r6_bypass", read_data[3], 32'h77);
    rst_n = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("midreset_r6", read_data[3], 32'd0);
    checkOutput("midreset_r5", read_data[0], 32'd0);
    checkOutput("midreset_count", cnt(), 32'd0);

    // Counter wrap: 15 writes, then a dual write brings it to 17 mod 16 = 1.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 1, 32'h10 + i, 1, 2, 32'h20 + i, 0, 0);
    end
    applyStimulus(1, 3, 32'h33, 0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    checkOutput("pre_wrap_count", cnt(), 32'd15);
    applyStimulus(1, 10, 32'hA, 1, 11, 32'hB, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    checkOutput("wrap_count", cnt(), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
